fib_checker: RTL

FIB_CHECKER -- requirements
Module: fib_checker

---
 rtl/fib_pkg.sv | 16 +
 rtl/fib_bin_scan.sv | 62 ++++++
 rtl/fib_checker.sv | 106 ++++++++++
 3 files changed

// File: rtl/fib_pkg.sv
// rtl/fib_pkg.sv - shared types and constants for the Fibonacci checker
package fib_pkg;

  localparam int IDX_W = 6;

  localparam logic MODE_FIBBIN = 1'b0;
  localparam logic MODE_FIBNUM = 1'b1;

  typedef enum logic [1:0] {
    IDLE,
    SCAN,
    GEN,
    DONE
  } state_t;

endpackage

// File: rtl/fib_bin_scan.sv
// rtl/fib_bin_scan.sv - serial LSB-first scanner for adjacent ones and popcount
module fib_bin_scan
  import fib_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             load,
  input  logic             step,
  input  logic [WIDTH-1:0] value,
  output logic             last,
  output logic             match,
  output logic [IDX_W-1:0] count
);

  localparam logic [IDX_W-1:0] LAST_BIT = IDX_W'(WIDTH - 1);

  logic [WIDTH-1:0] sh;
  logic             prev;
  logic             adj;
  logic [IDX_W-1:0] pop;
  logic [IDX_W-1:0] cnt;

  logic             cur;
  logic             adj_nxt;
  logic [IDX_W-1:0] pop_nxt;

  // Outputs already include the bit under examination, so the FSM can
  // finish on the same edge that consumes the MSB.
  always_comb begin
    cur     = sh[0];
    adj_nxt = adj | (prev & cur);
    pop_nxt = pop + IDX_W'(cur);
    last    = (cnt == LAST_BIT);
    match   = ~adj_nxt;
    count   = pop_nxt;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      sh   <= '0;
      prev <= 1'b0;
      adj  <= 1'b0;
      pop  <= '0;
      cnt  <= '0;
    end else if (load) begin
      sh   <= value;
      prev <= 1'b0;
      adj  <= 1'b0;
      pop  <= '0;
      cnt  <= '0;
    end else if (step) begin
      sh   <= sh >> 1;
      prev <= cur;
      adj  <= adj_nxt;
      pop  <= pop_nxt;
      cnt  <= cnt + IDX_W'(1);
    end
  end

endmodule

// File: rtl/fib_checker.sv
// rtl/fib_checker.sv - fibbinary / Fibonacci-membership checker with valid/ready handshake
module fib_checker
  import fib_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] value,
  input  logic             mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             is_match,
  output logic [IDX_W-1:0] fib_index
);

  state_t           state;
  logic [WIDTH+1:0] a;
  logic [WIDTH+1:0] b;
  logic [IDX_W-1:0] k;
  logic [WIDTH-1:0] val;
  logic [WIDTH+1:0] val_ext;

  logic             accept;
  logic             scan_last;
  logic             scan_match;
  logic [IDX_W-1:0] scan_count;

  assign accept  = in_valid && in_ready;
  assign val_ext = {2'b00, val};

  fib_bin_scan #(.WIDTH(WIDTH)) u_scan (
    .clk     (clk),
    .reset_n (reset_n),
    .load    (accept && (mode == MODE_FIBBIN)),
    .step    (state == SCAN),
    .value   (value),
    .last    (scan_last),
    .match   (scan_match),
    .count   (scan_count)
  );

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      is_match  <= 1'b0;
      fib_index <= '0;
      a         <= '0;
      b         <= (WIDTH+2)'(1);
      k         <= '0;
      val       <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            in_ready <= 1'b0;
            val      <= value;
            a        <= '0;
            b        <= (WIDTH+2)'(1);
            k        <= '0;
            state    <= (mode == MODE_FIBNUM) ? GEN : SCAN;
          end
        end
        SCAN: begin
          if (scan_last) begin
            is_match  <= scan_match;
            fib_index <= scan_count;
            out_valid <= 1'b1;
            state     <= DONE;
          end
        end
        GEN: begin
          // a walks F(0), F(1), ...; the first a >= val ends the search.
          if (a == val_ext) begin
            is_match  <= 1'b1;
            fib_index <= k;
            out_valid <= 1'b1;
            state     <= DONE;
          end else if (a > val_ext) begin
            is_match  <= 1'b0;
            fib_index <= k;
            out_valid <= 1'b1;
            state     <= DONE;
          end else begin
            a <= b;
            b <= a + b;
            k <= k + IDX_W'(1);
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
